ip4_sm_arb: RTL

Round-robin arbiter and sequencer that shares one IP4 scratch-memory bank (single-port, synchronous read, one-cycle read latency, write when `wen` high) among `NREQ` requesters. Each cycle it picks at most one requester, registers its access onto the bank port, and routes read data back to the originator with a tagged valid pulse. A bounded lock lets one requester hold the bank for back-to-back accesses without starvation of the others.

---
 rtl/ip4_sm_arb.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ip4_sm_arb.sv
// Round-robin arbiter sharing one single-port IP4 scratch-memory bank among NREQ requesters.
// Registers the winning access onto the bank port and returns read data with a tagged valid pulse.
module ip4_sm_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned ADR_W    = 10,
  parameter int unsigned DAT_W    = 32,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_wen,
  input  logic [NREQ-1:0]         req_lock,
  input  logic [NREQ*ADR_W-1:0]   req_adr,
  input  logic [NREQ*DAT_W-1:0]   req_dat,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rvld,
  output logic [DAT_W-1:0]        rdat,
  output logic                    sm_wen,
  output logic [ADR_W-1:0]        sm_adr,
  output logic [DAT_W-1:0]        sm_datai,
  input  logic [DAT_W-1:0]        sm_datao
);

  localparam int unsigned PW = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam logic [7:0]  LM = 8'(LOCK_MAX);

  typedef logic [PW-1:0] id_t;
  typedef enum logic {ST_IDLE, ST_LOCKED} lock_st_e;

  lock_st_e           state_q, state_d;
  id_t                ptr_q, ptr_d;
  id_t                own_q, own_d;
  logic [7:0]         lcnt_q, lcnt_d;

  logic               sm_wen_q, sm_wen_d;
  logic [ADR_W-1:0]   sm_adr_q, sm_adr_d;
  logic [DAT_W-1:0]   sm_datai_q, sm_datai_d;
  logic               iss_rd_q, iss_rd_d;
  id_t                iss_id_q, iss_id_d;
  logic               ret_vld_q;
  id_t                ret_id_q;

  logic [ADR_W-1:0]   adr_a [NREQ];
  logic [DAT_W-1:0]   dat_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign adr_a[g] = req_adr[g*ADR_W +: ADR_W];
    assign dat_a[g] = req_dat[g*DAT_W +: DAT_W];
  end

  logic               acc;
  logic               hold;
  id_t                win;
  id_t                win_nxt;
  id_t                idx;
  logic [7:0]         lcnt_inc;

  // Arbitration: a live lock owner wins outright, otherwise scan from ptr.
  always_comb begin
    acc  = 1'b0;
    win  = '0;
    idx  = '0;
    hold = (state_q == ST_LOCKED) && req[own_q];
    if (hold) begin
      acc = 1'b1;
      win = own_q;
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = id_t'((32'(ptr_q) + k) % NREQ);
        if (!acc && req[idx]) begin
          acc = 1'b1;
          win = idx;
        end
      end
    end
    gnt = '0;
    if (acc) gnt[win] = 1'b1;
    win_nxt = (win == id_t'(NREQ - 1)) ? '0 : win + 1'b1;
  end

  // Lock sequencing. ptr is always loaded with winner+1 on accept; during a lock
  // the winner is the owner, so ptr stays at own+1 for the whole lock.
  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    lcnt_d   = lcnt_q;
    ptr_d    = ptr_q;
    lcnt_inc = (lcnt_q >= LM) ? LM : lcnt_q + 8'd1;
    if (!hold) state_d = ST_IDLE;
    if (acc) begin
      ptr_d = win_nxt;
      if (hold) begin
        if (req_lock[win]) begin
          lcnt_d = lcnt_inc;
          if (lcnt_inc >= LM) state_d = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end else if (req_lock[win]) begin
        own_d  = win;
        lcnt_d = 8'd1;
        if (LM > 8'd1) state_d = ST_LOCKED;
      end
    end
  end

  always_comb begin
    sm_wen_d   = acc & req_wen[win];
    sm_adr_d   = acc ? adr_a[win] : sm_adr_q;
    sm_datai_d = acc ? dat_a[win] : sm_datai_q;
    iss_rd_d   = acc & ~req_wen[win];
    iss_id_d   = acc ? win : iss_id_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      own_q      <= '0;
      lcnt_q     <= '0;
      sm_wen_q   <= 1'b0;
      sm_adr_q   <= '0;
      sm_datai_q <= '0;
      iss_rd_q   <= 1'b0;
      iss_id_q   <= '0;
      ret_vld_q  <= 1'b0;
      ret_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      own_q      <= own_d;
      lcnt_q     <= lcnt_d;
      sm_wen_q   <= sm_wen_d;
      sm_adr_q   <= sm_adr_d;
      sm_datai_q <= sm_datai_d;
      iss_rd_q   <= iss_rd_d;
      iss_id_q   <= iss_id_d;
      ret_vld_q  <= iss_rd_q;
      ret_id_q   <= iss_id_q;
    end
  end

  always_comb begin
    rvld = '0;
    if (ret_vld_q) rvld[ret_id_q] = 1'b1;
  end

  assign rdat     = sm_datao;
  assign sm_wen   = sm_wen_q;
  assign sm_adr   = sm_adr_q;
  assign sm_datai = sm_datai_q;

endmodule
